apb_master_fsm: RTL and testbench

- Upstream stage of every APB slave in the bridge: converts single-beat commands from the AXI4-Lite front end into APB4 SETUP/ACCESS transfers.
- Drives the master side of the APB interface and returns read data, error and timeout status on a valid/ready response channel.
- One outstanding transfer at a time; built-in PREADY timeout so a hung slave cannot stall the bridge.

---
 rtl/apb_master_fsm.sv | 138 +++++++++++++
 tb/tb_apb_master_fsm.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_fsm.sv
// APB4 master: turns single-beat commands into SETUP/ACCESS transfers and
// returns read data plus error/timeout status on a valid/ready response port.
// One transfer in flight; a PREADY timeout keeps a hung slave from stalling it.
module apb_master_fsm #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    pclk,
    input  logic                    preset,
    // command channel
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    input  logic [2:0]              cmd_prot,
    // response channel
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    // APB master side
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [2:0]              pprot,
    output logic                    pselx,
    output logic                    penable,
    output logic                    pwrite,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic                    pready,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pslverr
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    // The counter only has to reach TIMEOUT_CYCLES-1: the abort happens in the
    // ACCESS cycle where that value is seen together with pready=0.
    localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] wait_cnt;

    // Command acceptance depends on the state register alone.
    // NOTE: decoding cmd_ready from state only keeps it free of any
    // combinational path from cmd_valid, so upstream can't form a loop.
    assign cmd_ready = (state == IDLE);

    // Transfer sequencer: all APB and response outputs are registered here.
    // NOTE: non-blocking assignments throughout, so every register in this
    // block sees the pre-edge values of the others regardless of statement order.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            pselx       <= 1'b0;
            penable     <= 1'b0;
            paddr       <= '0;
            pprot       <= '0;
            pwrite      <= 1'b0;
            pwdata      <= '0;
            pstrb       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        paddr  <= cmd_addr;
                        pprot  <= cmd_prot;
                        pwrite <= cmd_write;
                        pwdata <= cmd_wdata;
                        // APB4 requires all strobes low on a read.
                        pstrb  <= cmd_write ? cmd_wstrb : {STRB_WIDTH{1'b0}};
                        pselx  <= 1'b1;
                        state  <= SETUP;
                    end
                end

                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end

                ACCESS: begin
                    if (pready) begin
                        // A slave completing on the timeout cycle still wins.
                        rsp_rdata   <= pwrite ? {DATA_WIDTH{1'b0}} : prdata;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        pselx       <= 1'b0;
                        penable     <= 1'b0;
                        wait_cnt    <= '0;
                        state       <= RESP;
                    end else if (TIMEOUT_EN && (wait_cnt == CNT_LAST)) begin
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        pselx       <= 1'b0;
                        penable     <= 1'b0;
                        wait_cnt    <= '0;
                        state       <= RESP;
                    end else if (TIMEOUT_EN) begin
                        wait_cnt <= wait_cnt + CNT_WIDTH'(1);
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        wait_cnt  <= '0;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_fsm.sv
// Testbench for apb_master_fsm: directed transfers against a small APB slave,
// checked every cycle against a transaction-level timing model, plus literal
// expectations for latency, access-cycle counts and response fields.
module tb_apb_master_fsm;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    logic          pclk = 1'b0;
    logic          preset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [SW-1:0] cmd_wstrb = '0;
    logic [2:0]    cmd_prot = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic [AW-1:0] paddr;
    logic [2:0]    pprot;
    logic          pselx;
    logic          penable;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic          pready = 1'b0;
    logic [DW-1:0] prdata = '0;
    logic          pslverr = 1'b0;

    always #5 pclk = ~pclk;

    apb_master_fsm #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .pclk(pclk),
        .preset(preset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .cmd_wstrb(cmd_wstrb),
        .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .paddr(paddr),
        .pprot(pprot),
        .pselx(pselx),
        .penable(penable),
        .pwrite(pwrite),
        .pwdata(pwdata),
        .pstrb(pstrb),
        .pready(pready),
        .prdata(prdata),
        .pslverr(pslverr)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- APB slave: answers after slv_waits wait states ----------
    int            slv_waits = 0;
    logic [DW-1:0] slv_rdata = '0;
    logic          slv_err = 1'b0;
    int            acc_n = 0;

    always @(posedge pclk) begin
        #1;
        if (pselx === 1'b1 && penable === 1'b1) acc_n++;
        else acc_n = 0;
        if (acc_n != 0 && acc_n == slv_waits + 1) begin
            pready  = 1'b1;
            prdata  = slv_rdata;
            pslverr = slv_err;
        end else begin
            pready  = 1'b0;
            prdata  = 32'hBAD0_0000 | 32'(acc_n);
            pslverr = slv_err;
        end
    end

    // ---------------- transaction-level model + per-cycle compare -------------
    // A transfer is described by how many cycles have elapsed since acceptance:
    // cycle 1 is SETUP, the next n_access cycles are ACCESS, then the response
    // is held until rsp_ready. n_access and the response come straight from the
    // slave's configured wait states and the timeout limit.
    bit            chk_en = 1'b0;
    bit            m_busy = 1'b0;
    int            m_k = 0;
    int            m_nacc = 0;
    logic          m_write;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [SW-1:0] m_strb;
    logic [2:0]    m_prot;
    logic [DW-1:0] m_rdata;
    logic          m_err;
    logic          m_to;
    logic          exp_ready, exp_sel, exp_en, exp_rv;
    int            cyc = 0;
    int            acc_cyc = 0;
    int            obs_lat = 0;
    int            obs_acc = 0;
    logic          prev_rv = 1'b0;

    always @(negedge pclk) begin
        if (chk_en) begin
            cyc++;
            exp_ready = !m_busy;
            exp_sel   = 1'b0;
            exp_en    = 1'b0;
            exp_rv    = 1'b0;
            if (m_busy) begin
                if (m_k == 1) exp_sel = 1'b1;
                else if (m_k <= 1 + m_nacc) begin
                    exp_sel = 1'b1;
                    exp_en  = 1'b1;
                end else exp_rv = 1'b1;
            end
            check("cmd_ready", 64'(cmd_ready), 64'(exp_ready));
            check("pselx", 64'(pselx), 64'(exp_sel));
            check("penable", 64'(penable), 64'(exp_en));
            check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
            check("penable_without_psel", 64'(penable & ~pselx), 64'(0));
            if (exp_sel) begin
                check("paddr", 64'(paddr), 64'(m_addr));
                check("pwrite", 64'(pwrite), 64'(m_write));
                check("pwdata", 64'(pwdata), 64'(m_wdata));
                check("pstrb", 64'(pstrb), 64'(m_strb));
                check("pprot", 64'(pprot), 64'(m_prot));
            end
            if (exp_rv) begin
                check("rsp_rdata", 64'(rsp_rdata), 64'(m_rdata));
                check("rsp_err", 64'(rsp_err), 64'(m_err));
                check("rsp_timeout", 64'(rsp_timeout), 64'(m_to));
            end
            // observations used by the literal checks in the stimulus
            if (pselx === 1'b1 && penable === 1'b1) obs_acc++;
            if (rsp_valid === 1'b1 && prev_rv !== 1'b1) obs_lat = cyc - acc_cyc;
            prev_rv = rsp_valid;
            // advance the model to what the coming edge must produce
            if (preset) begin
                m_busy = 1'b0;
            end else if (!m_busy) begin
                if (cmd_valid) begin
                    m_busy  = 1'b1;
                    m_k     = 1;
                    m_write = cmd_write;
                    m_addr  = cmd_addr;
                    m_wdata = cmd_wdata;
                    m_strb  = cmd_write ? cmd_wstrb : '0;
                    m_prot  = cmd_prot;
                    if (slv_waits + 1 > TO) begin
                        m_nacc  = TO;
                        m_rdata = '0;
                        m_err   = 1'b1;
                        m_to    = 1'b1;
                    end else begin
                        m_nacc  = slv_waits + 1;
                        m_rdata = cmd_write ? '0 : slv_rdata;
                        m_err   = slv_err;
                        m_to    = 1'b0;
                    end
                    acc_cyc = cyc;
                    obs_acc = 0;
                end
            end else if (m_k > 1 + m_nacc) begin
                if (rsp_ready) m_busy = 1'b0;
            end else begin
                m_k++;
            end
        end
    end

    // ---------------- stimulus helpers ---------------------------------------
    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [SW-1:0] st, input logic [2:0] pr, input int waits,
                        input logic [DW-1:0] rd, input logic er);
        bit ok = 1'b0;
        slv_waits = waits;
        slv_rdata = rd;
        slv_err   = er;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = wd;
        cmd_wstrb = st;
        cmd_prot  = pr;
        cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge pclk);
            if (cmd_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("cmd_accepted", 64'(ok), 64'(1));
        @(posedge pclk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [DW-1:0] rd, output logic er, output logic to);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge pclk);
            if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("rsp_arrived", 64'(ok), 64'(1));
        rd = rsp_rdata;
        er = rsp_err;
        to = rsp_timeout;
        @(posedge pclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence --------------------------------------
    initial begin
        logic [DW-1:0] rd;
        logic          er, to;
        int            a1;
        bit            seen;

        @(posedge pclk);
        #1;
        chk_en = 1'b1;
        check("rst_pselx", 64'(pselx), 64'(0));
        check("rst_penable", 64'(penable), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        check("rst_paddr", 64'(paddr), 64'(0));
        check("rst_pwdata", 64'(pwdata), 64'(0));
        check("rst_pstrb", 64'(pstrb), 64'(0));
        check("rst_pwrite", 64'(pwrite), 64'(0));
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        check("rst_rsp_err", 64'(rsp_err), 64'(0));
        check("rst_rsp_timeout", 64'(rsp_timeout), 64'(0));
        repeat (2) @(posedge pclk);
        #1;
        preset = 1'b0;
        @(posedge pclk);
        #1;

        // read, zero wait states
        send(1'b0, 32'h10, 32'hFFFF_FFFF, 4'hF, 3'b010, 0, 32'hDEAD_BEEF, 1'b0);
        wait_rsp(rd, er, to);
        check("rd0_rdata", 64'(rd), 64'h0000_0000_DEAD_BEEF);
        check("rd0_err", 64'(er), 64'(0));
        check("rd0_timeout", 64'(to), 64'(0));
        check("rd0_latency", 64'(obs_lat), 64'(3));
        check("rd0_access_cycles", 64'(obs_acc), 64'(1));

        // write, two wait states
        send(1'b1, 32'h20, 32'h1234_5678, 4'hF, 3'b000, 2, 32'hCAFE_F00D, 1'b0);
        wait_rsp(rd, er, to);
        check("wr2_rdata", 64'(rd), 64'(0));
        check("wr2_err", 64'(er), 64'(0));
        check("wr2_latency", 64'(obs_lat), 64'(5));
        check("wr2_access_cycles", 64'(obs_acc), 64'(3));

        // slave error on a read
        send(1'b0, 32'h30, 32'h0, 4'hF, 3'b001, 1, 32'h5555_AAAA, 1'b1);
        wait_rsp(rd, er, to);
        check("slverr_rdata", 64'(rd), 64'h0000_0000_5555_AAAA);
        check("slverr_err", 64'(er), 64'(1));
        check("slverr_timeout", 64'(to), 64'(0));

        // slave never ready: timeout after exactly TO access cycles
        send(1'b0, 32'h40, 32'h0, 4'h0, 3'b100, 100, 32'h7777_7777, 1'b0);
        wait_rsp(rd, er, to);
        check("to_rdata", 64'(rd), 64'(0));
        check("to_err", 64'(er), 64'(1));
        check("to_timeout", 64'(to), 64'(1));
        check("to_access_cycles", 64'(obs_acc), 64'(4));
        check("to_latency", 64'(obs_lat), 64'(6));

        // slave ready on the last allowed access cycle: normal completion
        send(1'b0, 32'h44, 32'h0, 4'h0, 3'b000, 3, 32'h0BAD_CAFE, 1'b0);
        wait_rsp(rd, er, to);
        check("edge_rdata", 64'(rd), 64'h0000_0000_0BAD_CAFE);
        check("edge_err", 64'(er), 64'(0));
        check("edge_timeout", 64'(to), 64'(0));
        check("edge_access_cycles", 64'(obs_acc), 64'(4));

        // back-to-back zero-wait transfers: 4-cycle issue interval
        send(1'b1, 32'h50, 32'hA0A0_A0A0, 4'h5, 3'b000, 0, 32'h0, 1'b0);
        a1 = acc_cyc;
        wait_rsp(rd, er, to);
        send(1'b0, 32'h54, 32'h0, 4'hF, 3'b000, 0, 32'h1357_9BDF, 1'b0);
        check("issue_interval", 64'(acc_cyc - a1), 64'(4));
        wait_rsp(rd, er, to);
        check("b2b_rdata", 64'(rd), 64'h0000_0000_1357_9BDF);

        // response backpressure with a queued command
        rsp_ready = 1'b0;
        send(1'b0, 32'h60, 32'h0, 4'h0, 3'b000, 0, 32'h1111_2222, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge pclk);
            if (rsp_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("bp_rsp_seen", 64'(seen), 64'(1));
        @(posedge pclk);
        #1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h64;
        cmd_wdata = 32'h9999_8888;
        cmd_wstrb = 4'hC;
        cmd_prot  = 3'b011;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge pclk);
            check("bp_cmd_ready", 64'(cmd_ready), 64'(0));
            check("bp_pselx", 64'(pselx), 64'(0));
            check("bp_rdata_hold", 64'(rsp_rdata), 64'h0000_0000_1111_2222);
        end
        @(posedge pclk);
        #1;
        rsp_ready = 1'b1;
        a1 = cyc;
        send(1'b1, 32'h64, 32'h9999_8888, 4'hC, 3'b011, 0, 32'h0, 1'b0);
        check("bp_queued_accept_delay", 64'(acc_cyc - a1), 64'(2));
        wait_rsp(rd, er, to);
        check("bp_queued_rdata", 64'(rd), 64'(0));

        // reset during an ACCESS wait state
        send(1'b1, 32'h70, 32'hA5A5_A5A5, 4'h3, 3'b000, 100, 32'h0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge pclk);
            if (penable === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("mid_access_reached", 64'(seen), 64'(1));
        @(posedge pclk);
        #1;
        preset = 1'b1;
        @(posedge pclk);
        #1;
        preset = 1'b0;
        check("mid_rst_pselx", 64'(pselx), 64'(0));
        check("mid_rst_penable", 64'(penable), 64'(0));
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("mid_rst_cmd_ready", 64'(cmd_ready), 64'(1));

        // recovery transfer after the abort
        send(1'b0, 32'h80, 32'h0, 4'h0, 3'b000, 1, 32'h2468_ACE0, 1'b0);
        wait_rsp(rd, er, to);
        check("post_rst_rdata", 64'(rd), 64'h0000_0000_2468_ACE0);
        check("post_rst_latency", 64'(obs_lat), 64'(4));

        repeat (3) @(posedge pclk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
